// File: rtl/rf_cmd_sched.sv
// rf_cmd_sched: buffers RF move/load/store commands and issues them one at a time
// to the move or load/store engine. Define RF_SCHED_TIMEOUT_EN to add a WAIT watchdog.
module rf_cmd_sched #(
   parameter int ADDR_W       = 10,
   parameter int LINE_NUM_W   = 11,
   parameter int SDRAM_ADDR_W = 32,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [ADDR_W-1:0]       cmd_src,
   input  logic [ADDR_W-1:0]       cmd_dst,
   input  logic [LINE_NUM_W-1:0]   cmd_len,
   input  logic [SDRAM_ADDR_W-1:0] cmd_sdram_addr,
   output logic                    ram_sel,
   output logic                    move_start,
   output logic [ADDR_W-1:0]       move_src,
   output logic [ADDR_W-1:0]       move_dst,
   output logic [LINE_NUM_W-1:0]   move_len,
   output logic                    ldst_start,
   output logic                    ldst_is_store,
   output logic [ADDR_W-1:0]       ldst_rf_addr,
   output logic [SDRAM_ADDR_W-1:0] ldst_sdram_addr,
   output logic [LINE_NUM_W-1:0]   ldst_len,
   input  logic                    move_done,
   input  logic                    ldst_done,
   output logic                    busy,
   output logic                    cmd_done,
   output logic                    cmd_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] OP_MOVE    = 2'd0;
   localparam logic [1:0] OP_STORE   = 2'd2;
   localparam logic [1:0] OP_ILLEGAL = 2'd3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CHECK  = 3'd1;
   localparam logic [2:0] ST_SEL    = 3'd2;
   localparam logic [2:0] ST_LAUNCH = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_RETIRE = 3'd5;

   typedef struct packed {
      logic [1:0]              op;
      logic [ADDR_W-1:0]       src;
      logic [ADDR_W-1:0]       dst;
      logic [LINE_NUM_W-1:0]   len;
      logic [SDRAM_ADDR_W-1:0] addr;
   } cmd_t;

   cmd_t             fifo_mem [FIFO_DEPTH];
   cmd_t             cmd_in;
   cmd_t             cmd_q;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [2:0]       state;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             cmd_bad;
   logic             tgt_sel;
   logic             engine_done;
   logic             timeout_hit;

   assign cmd_in     = '{op: cmd_op, src: cmd_src, dst: cmd_dst, len: cmd_len, addr: cmd_sdram_addr};
   assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == ST_IDLE) && !fifo_empty;

   // NOTE: payload storage is deliberately not reset; count/pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_in;
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign cmd_bad     = (cmd_q.op == OP_ILLEGAL) || (cmd_q.len == '0);
   assign tgt_sel     = (cmd_q.op != OP_MOVE);
   // Only the launched engine can retire the command; the other engine's done is ignored.
   assign engine_done = tgt_sel ? ldst_done : move_done;

`ifdef RF_SCHED_TIMEOUT_EN
   logic [15:0] wdog;

   assign timeout_hit = (state == ST_WAIT) && !engine_done && (wdog == 16'hFFFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 wdog <= '0;
      else if (state == ST_LAUNCH) wdog <= '0;
      else if (state == ST_WAIT)   wdog <= wdog + 16'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cmd_q           <= '0;
         ram_sel         <= 1'b0;
         move_src        <= '0;
         move_dst        <= '0;
         move_len        <= '0;
         ldst_is_store   <= 1'b0;
         ldst_rf_addr    <= '0;
         ldst_sdram_addr <= '0;
         ldst_len        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  cmd_q <= fifo_mem[rd_ptr];
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (cmd_bad) begin
                  state <= ST_IDLE;
               end else begin
                  // Switching here makes SEL the guard cycle in which the RAM mux settles.
                  ram_sel <= tgt_sel;
                  state   <= ST_SEL;
               end
            end
            ST_SEL: begin
               if (tgt_sel) begin
                  ldst_is_store   <= (cmd_q.op == OP_STORE);
                  ldst_rf_addr    <= (cmd_q.op == OP_STORE) ? cmd_q.src : cmd_q.dst;
                  ldst_sdram_addr <= cmd_q.addr;
                  ldst_len        <= cmd_q.len;
               end else begin
                  move_src <= cmd_q.src;
                  move_dst <= cmd_q.dst;
                  move_len <= cmd_q.len;
               end
               state <= ST_LAUNCH;
            end
            ST_LAUNCH: state <= ST_WAIT;
            ST_WAIT: begin
               if (engine_done)      state <= ST_RETIRE;
               else if (timeout_hit) state <= ST_IDLE;
            end
            ST_RETIRE: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   assign move_start = (state == ST_LAUNCH) && !tgt_sel;
   assign ldst_start = (state == ST_LAUNCH) && tgt_sel;
   assign cmd_done   = (state == ST_RETIRE);
   assign cmd_err    = ((state == ST_CHECK) && cmd_bad) || timeout_hit;
   assign busy       = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_rf_cmd_sched.sv
// Scoreboard bench for rf_cmd_sched: random commands vs. a command-level reference model,
// with an engine responder that injects early and cross-engine done pulses.
`timescale 1ns/1ps
module tb_rf_cmd_sched;
   localparam int ADDR_W       = 10;
   localparam int LINE_NUM_W   = 11;
   localparam int SDRAM_ADDR_W = 32;
   localparam int FIFO_DEPTH   = 4;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    cmd_valid = 1'b0;
   logic                    cmd_ready;
   logic [1:0]              cmd_op = '0;
   logic [ADDR_W-1:0]       cmd_src = '0;
   logic [ADDR_W-1:0]       cmd_dst = '0;
   logic [LINE_NUM_W-1:0]   cmd_len = '0;
   logic [SDRAM_ADDR_W-1:0] cmd_sdram_addr = '0;
   logic                    ram_sel;
   logic                    move_start;
   logic [ADDR_W-1:0]       move_src;
   logic [ADDR_W-1:0]       move_dst;
   logic [LINE_NUM_W-1:0]   move_len;
   logic                    ldst_start;
   logic                    ldst_is_store;
   logic [ADDR_W-1:0]       ldst_rf_addr;
   logic [SDRAM_ADDR_W-1:0] ldst_sdram_addr;
   logic [LINE_NUM_W-1:0]   ldst_len;
   logic                    move_done = 1'b0;
   logic                    ldst_done = 1'b0;
   logic                    busy;
   logic                    cmd_done;
   logic                    cmd_err;

   always #5 clk = ~clk;

   rf_cmd_sched #(
      .ADDR_W(ADDR_W), .LINE_NUM_W(LINE_NUM_W),
      .SDRAM_ADDR_W(SDRAM_ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .cmd_sdram_addr(cmd_sdram_addr), .ram_sel(ram_sel),
      .move_start(move_start), .move_src(move_src), .move_dst(move_dst), .move_len(move_len),
      .ldst_start(ldst_start), .ldst_is_store(ldst_is_store), .ldst_rf_addr(ldst_rf_addr),
      .ldst_sdram_addr(ldst_sdram_addr), .ldst_len(ldst_len),
      .move_done(move_done), .ldst_done(ldst_done),
      .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err)
   );

   typedef struct {
      bit                      is_ldst;
      bit                      is_store;
      logic [ADDR_W-1:0]       src;
      logic [ADDR_W-1:0]       dst;
      logic [ADDR_W-1:0]       rf_addr;
      logic [LINE_NUM_W-1:0]   len;
      logic [SDRAM_ADDR_W-1:0] addr;
   } launch_t;

   launch_t exp_launch[$];
   bit      exp_retire[$];   // 1 = rejected (cmd_err), 0 = retired (cmd_done)
   launch_t cur_launch;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   hold_done = 1'b0;
   bit   abort_rsp = 1'b0;
   bit   real_done_given = 1'b0;
   bit   model_sel = 1'b0;
   logic prev_ram_sel = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: what each accepted command must eventually produce.
   task automatic model_push(input logic [1:0] op, input logic [ADDR_W-1:0] src,
                             input logic [ADDR_W-1:0] dst, input logic [LINE_NUM_W-1:0] len,
                             input logic [SDRAM_ADDR_W-1:0] addr);
      launch_t e;
      if (op == 2'd3 || len == 0) begin
         exp_retire.push_back(1'b1);
      end else begin
         e.is_ldst  = (op != 2'd0);
         e.is_store = (op == 2'd2);
         e.src      = src;
         e.dst      = dst;
         e.rf_addr  = (op == 2'd1) ? dst : src;
         e.len      = len;
         e.addr     = addr;
         exp_launch.push_back(e);
         exp_retire.push_back(1'b0);
      end
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] src,
                            input logic [ADDR_W-1:0] dst, input logic [LINE_NUM_W-1:0] len,
                            input logic [SDRAM_ADDR_W-1:0] addr);
      cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_sdram_addr = addr;
      cmd_valid = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
   task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] src,
                        input logic [ADDR_W-1:0] dst, input logic [LINE_NUM_W-1:0] len,
                        input logic [SDRAM_ADDR_W-1:0] addr);
      int w = 0;
      drive_cmd(op, src, dst, len, addr);
      while (!cmd_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) fail("accept_timeout");
      else model_push(op, src, dst, len, addr);
      @(negedge clk);
   endtask

   task automatic drain();
      int w = 0;
      cmd_valid = 1'b0;
      while ((exp_launch.size() != 0 || exp_retire.size() != 0) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) fail("drain_timeout");
      @(negedge clk);
      @(negedge clk);
      check("busy_after_drain", busy, 1'b0);
   endtask

   task automatic set_done(input bit eng, input logic v);
      if (eng) ldst_done = v;
      else     move_done = v;
   endtask

   task automatic set_other(input bit eng, input logic v);
      if (eng) move_done = v;
      else     ldst_done = v;
   endtask

   // Engine responder: optional ignored pulse in LAUNCH, cross-engine noise, then the real done.
   task automatic respond();
      bit eng = ldst_start;
      int n = $urandom_range(1, 8);
      real_done_given = 1'b0;
      if ($urandom_range(0, 3) == 0) set_done(eng, 1'b1);
      @(negedge clk);
      set_done(eng, 1'b0);
      while ((n > 0 || hold_done) && !abort_rsp) begin
         if ($urandom_range(0, 2) == 0) set_other(eng, 1'b1);
         @(negedge clk);
         set_other(eng, 1'b0);
         if (n > 0) n--;
      end
      if (!abort_rsp) begin
         if (eng) begin
            check("hold_is_store", ldst_is_store, cur_launch.is_store);
            check("hold_rf_addr", ldst_rf_addr, cur_launch.rf_addr);
            check("hold_sdram", ldst_sdram_addr, cur_launch.addr);
            check("hold_ldst_len", ldst_len, cur_launch.len);
         end else begin
            check("hold_move_src", move_src, cur_launch.src);
            check("hold_move_dst", move_dst, cur_launch.dst);
            check("hold_move_len", move_len, cur_launch.len);
         end
         real_done_given = 1'b1;
         set_done(eng, 1'b1);
         @(negedge clk);
         set_done(eng, 1'b0);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en && (move_start || ldst_start)) respond();
   end

   // Monitor: pops the scoreboard whenever the DUT launches or retires.
   initial forever begin
      launch_t e;
      bit k;
      @(negedge clk);
      if (mon_en) begin
         if (move_start || ldst_start) begin
            check("start_onehot", move_start && ldst_start, 1'b0);
            if (exp_launch.size() == 0) begin
               fail("unexpected_launch");
            end else begin
               e = exp_launch.pop_front();
               cur_launch = e;
               check("launch_engine", ldst_start, e.is_ldst);
               check("launch_ram_sel", ram_sel, e.is_ldst);
               check("guard_ram_sel", prev_ram_sel, e.is_ldst);
               if (e.is_ldst) begin
                  check("ldst_is_store", ldst_is_store, e.is_store);
                  check("ldst_rf_addr", ldst_rf_addr, e.rf_addr);
                  check("ldst_sdram_addr", ldst_sdram_addr, e.addr);
                  check("ldst_len", ldst_len, e.len);
               end else begin
                  check("move_src", move_src, e.src);
                  check("move_dst", move_dst, e.dst);
                  check("move_len", move_len, e.len);
               end
               model_sel = e.is_ldst;
            end
         end
         if (cmd_done || cmd_err) begin
            check("done_err_excl", cmd_done && cmd_err, 1'b0);
            if (exp_retire.size() == 0) begin
               fail("unexpected_retire");
            end else begin
               k = exp_retire.pop_front();
               check("retire_kind_err", cmd_err, k);
               if (cmd_done) check("done_after_engine", real_done_given, 1'b1);
               if (cmd_err)  check("err_ram_sel_held", ram_sel, model_sel);
            end
         end
      end
      prev_ram_sel = ram_sel;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_ram_sel"}, ram_sel, 1'b0);
      check({tag, "_pulses"}, {move_start, ldst_start, cmd_done, cmd_err}, 4'b0);
      check({tag, "_move_ops"}, {move_src, move_dst, move_len}, '0);
      check({tag, "_ldst_ops"}, {ldst_is_store, ldst_rf_addr, ldst_len}, '0);
      check({tag, "_ldst_sdram"}, ldst_sdram_addr, '0);
   endtask

   initial begin
      int n;
      int acc;
      int quiet;
      logic [1:0] op;
      logic [ADDR_W-1:0] p_src;
      logic [LINE_NUM_W-1:0] p_len;

      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single move from idle: launch three cycles after acceptance.
      issue(2'd0, 10'd5, 10'd20, 11'd3, 32'd0);
      cmd_valid = 1'b0;
      n = 0;
      while (!move_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("move_launch_latency", n, 3);
      drain();

      // Back-to-back load then store.
      issue(2'd1, 10'd0, 10'd7, 11'd4, 32'h1000);
      issue(2'd2, 10'd9, 10'd0, 11'd2, 32'h2000);
      drain();

      // Illegal op and zero length: rejected with ram_sel untouched.
      issue(2'd3, 10'd1, 10'd2, 11'd3, 32'h30);
      issue(2'd0, 10'd1, 10'd2, 11'd0, 32'h0);
      drain();

      // Random mix.
      for (int i = 0; i < 60; i++) begin
         n = $urandom_range(0, 9);
         op = (n < 4) ? 2'd0 : (n < 7) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
         issue(op, ADDR_W'($urandom), ADDR_W'($urandom), LINE_NUM_W'($urandom_range(0, 7)),
               $urandom);
         if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
         end
      end
      drain();

      // Back-pressure: with the engine stalled, one command in flight plus a full FIFO.
      hold_done = 1'b1;
      acc = 0;
      p_src = '0;
      p_len = 11'd1;
      for (int i = 0; i < 10; i++) begin
         p_src = ADDR_W'($urandom);
         p_len = LINE_NUM_W'($urandom_range(1, 7));
         drive_cmd(2'd0, p_src, 10'd3, p_len, 32'd0);
         if (!cmd_ready) break;
         model_push(2'd0, p_src, 10'd3, p_len, 32'd0);
         acc++;
         @(negedge clk);
      end
      check("accepted_until_full", acc, FIFO_DEPTH + 1);
      check("ready_low_when_full", cmd_ready, 1'b0);
      @(negedge clk);
      check("ready_stays_low", cmd_ready, 1'b0);
      hold_done = 1'b0;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) fail("ready_never_returned");
      else model_push(2'd0, p_src, 10'd3, p_len, 32'd0);
      @(negedge clk);
      drain();

      // Reset while waiting on a store with two commands still queued.
      hold_done = 1'b1;
      issue(2'd2, 10'd11, 10'd0, 11'd5, 32'h4000);
      issue(2'd1, 10'd0, 10'd12, 11'd2, 32'h5000);
      issue(2'd0, 10'd13, 10'd14, 11'd1, 32'h0);
      cmd_valid = 1'b0;
      n = 0;
      while (exp_launch.size() != 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("pre_reset_ram_sel", ram_sel, 1'b1);
      mon_en = 1'b0;
      abort_rsp = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      exp_launch.delete();
      exp_retire.delete();
      model_sel = 1'b0;
      hold_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 0;
      repeat (12) begin
         @(negedge clk);
         quiet += int'(busy | move_start | ldst_start | cmd_done | cmd_err);
      end
      check("post_reset_quiet", quiet, 0);
      abort_rsp = 1'b0;
      mon_en = 1'b1;

      // Queue works again after the reset.
      issue(2'd1, 10'd0, 10'd21, 11'd6, 32'h6000);
      drain();

`ifdef RF_SCHED_TIMEOUT_EN
      // Watchdog: a withheld done turns into cmd_err 65535 cycles after entering WAIT.
      hold_done = 1'b1;
      drive_cmd(2'd0, 10'd2, 10'd4, 11'd2, 32'd0);
      model_push(2'd0, 10'd2, 10'd4, 11'd2, 32'd0);
      void'(exp_retire.pop_back());
      exp_retire.push_back(1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!move_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      acc = cyc;
      n = 0;
      while (!cmd_err && n < 70000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", cyc - acc, 65536);
      abort_rsp = 1'b1;
      hold_done = 1'b0;
      repeat (3) @(negedge clk);
      abort_rsp = 1'b0;
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
